sbox_rr_arbiter: RTL and testbench

- Shares one external DES S-box bank between up to 4 round engines (3DES stages) with round-robin arbitration.
- The bank is eight 6-to-4 substitution boxes, S1..S8, and is purely combinational.
- The block muxes the granted 48-bit request onto the bank, registers the 32-bit substitution result, and returns it with the requester ID over a valid/ready response channel.

---
 rtl/sbox_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_sbox_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_rr_arbiter.sv
// sbox_rr_arbiter: shares one external DES S-box bank between NREQ round engines, round-robin.
// Define SBOX_ARB_INPUT_REG_EN to insert an input stage register before the bank (latency 2).
module sbox_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 2
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*48-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [47:0]        sbox_in,
    input  logic [31:0]        sbox_out,
    output logic               rsp_valid,
    output logic [31:0]        rsp_data,
    output logic [ID_W-1:0]    rsp_id,
    input  logic               rsp_ready,
    output logic               busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    slot_state_t     state;
    slot_state_t     state_nxt;
    logic [ID_W-1:0] ptr;
    logic            can_accept;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic [47:0]     gnt_data;
    logic            load;
    logic [ID_W-1:0] load_id;

    // Search starts at ptr and wraps, so the most recently served requester is tried last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (can_accept && !gnt_valid && req_valid[i] && ((int'(ptr) + k) % NREQ == i)) begin
                    gnt_valid = 1'b1;
                    gnt_id    = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        gnt_data  = 48'h0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_valid && gnt_id == ID_W'(i)) begin
                req_ready[i] = 1'b1;
                gnt_data     = req_data[48*i +: 48];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr <= '0;
        end else if (gnt_valid) begin
            ptr <= ID_W'((int'(gnt_id) + 1) % NREQ);
        end
    end

`ifdef SBOX_ARB_INPUT_REG_EN
    logic            in_valid;
    logic [47:0]     in_data;
    logic [ID_W-1:0] in_id;

    // The input stage only advances into the slot when the slot can take it this cycle.
    assign load       = in_valid && ((state == EMPTY) || rsp_ready);
    assign can_accept = n_rst && (!in_valid || load);
    assign sbox_in    = in_valid ? in_data : 48'h0;
    assign load_id    = in_id;
    assign busy       = (|req_valid) || rsp_valid || in_valid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_valid <= 1'b0;
            in_data  <= 48'h0;
            in_id    <= '0;
        end else if (can_accept) begin
            in_valid <= gnt_valid;
            if (gnt_valid) begin
                in_data <= gnt_data;
                in_id   <= gnt_id;
            end
        end
    end
`else
    assign load       = gnt_valid;
    assign can_accept = n_rst && ((state == EMPTY) || rsp_ready);
    assign sbox_in    = gnt_data;
    assign load_id    = gnt_id;
    assign busy       = (|req_valid) || rsp_valid;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (rsp_ready && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid = (state == FULL);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rsp_data <= 32'h0;
            rsp_id   <= '0;
        end else if (load) begin
            rsp_data <= sbox_out;
            rsp_id   <= load_id;
        end
    end

endmodule

// File: tb/tb_sbox_rr_arbiter.sv
// tb_sbox_rr_arbiter: vector table plus corner sequences for sbox_rr_arbiter, with a
// behavioural DES S-box bank on sbox_in/sbox_out and a grant/response scoreboard.
module tb_sbox_rr_arbiter;
    localparam int NREQ = 2;
    localparam int ID_W = 2;

    // Rows 0..3 of S1..S8, 16 nibbles per row, entry 0 in the top nibble.
    localparam logic [255:0] SBTAB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    typedef struct {
        int          req;
        logic [47:0] data;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } rsp_t;

    logic               clk;
    logic               n_rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*48-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [47:0]        sbox_in;
    logic [31:0]        sbox_out;
    logic               rsp_valid;
    logic [31:0]        rsp_data;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_ready;
    logic               busy;

    int   nChecks = 0;
    int   nErrors = 0;
    vec_t vecs [5];
    rsp_t sbq [$];
    int   mPtr = 0;
    logic mFull = 1'b0;

    sbox_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sboxRef(input logic [47:0] x);
        logic [31:0]  r;
        logic [5:0]   b;
        logic [255:0] t;
        int           idx;
        r = 32'h0;
        for (int s = 0; s < 8; s++) begin
            b   = x[47-6*s -: 6];
            idx = int'({b[5], b[0]}) * 16 + int'(b[4:1]);
            t   = SBTAB[s];
            r[31-4*s -: 4] = t[255-4*idx -: 4];
        end
        return r;
    endfunction

    always_comb sbox_out = sboxRef(sbox_in);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raise one request, wait (bounded) for its grant, then drop it after the accepting edge.
    task automatic applyStimulus(input int r, input logic [47:0] d, output int waited);
        req_data[48*r +: 48] = d;
        req_valid[r] = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (req_ready[r] || waited >= 20) break;
            waited++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        checkOutput("grant_wait", 64'(waited), 64'(0));
    endtask

    // Reference round-robin model: predicts req_ready and queues the expected responses.
    always @(negedge clk) begin : monitor
        int              g;
        logic [NREQ-1:0] expReady;
        rsp_t            item;
        if (!n_rst) begin
            mPtr  = 0;
            mFull = 1'b0;
            sbq.delete();
            checkOutput("reset_req_ready", 64'(req_ready), 64'(0));
            checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        end else begin
            checkOutput("sb_rsp_valid", 64'(rsp_valid), 64'(mFull));
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("[TB] FAIL sb_unexpected_rsp: got id %0d data 0x%0h, expected no response", rsp_id, rsp_data);
                end else begin
                    checkOutput("sb_rsp_data", 64'(rsp_data), 64'(sbq[0].data));
                    checkOutput("sb_rsp_id", 64'(rsp_id), 64'(sbq[0].id));
                end
            end
            g = -1;
            expReady = '0;
            if (!mFull || rsp_ready) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
                end
            end
            if (g >= 0) expReady[g] = 1'b1;
            checkOutput("sb_req_ready", 64'(req_ready), 64'(expReady));
            if (rsp_valid && rsp_ready && sbq.size() > 0) void'(sbq.pop_front());
            if (g >= 0) begin
                item.id   = ID_W'(g);
                item.data = sboxRef(req_data[48*g +: 48]);
                sbq.push_back(item);
                mPtr  = (g + 1) % NREQ;
                mFull = 1'b1;
            end else if (rsp_ready) begin
                mFull = 1'b0;
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          waited;
        logic [63:0] rnd;
        vecs[0] = '{0, 48'h000000000000, 32'hEFA72C4D};
        vecs[1] = '{1, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
        vecs[2] = '{1, 48'h041041041041, 32'h03DDEAD1};
        vecs[3] = '{0, 48'h820820820820, 32'h40DA4917};
        vecs[4] = '{1, 48'h79E79E79E79E, 32'h7A8F9B17};

        n_rst     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_rst = 1'b1;
        @(negedge clk);
        checkOutput("init_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("init_rsp_data", 64'(rsp_data), 64'(0));
        checkOutput("init_rsp_id", 64'(rsp_id), 64'(0));
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].req, vecs[v].data, waited);
            @(negedge clk);
            checkOutput("tbl_rsp_valid", 64'(rsp_valid), 64'(1));
            checkOutput("tbl_rsp_data", 64'(rsp_data), 64'(vecs[v].expData));
            checkOutput("tbl_rsp_id", 64'(rsp_id), 64'(vecs[v].req));
            @(posedge clk);
            #1;
        end

        // Stalled slot blocks requester 1; the drain cycle must grant it with no bubble.
        rsp_ready = 1'b0;
        applyStimulus(0, 48'h820820820820, waited);
        req_data[95:48] = 48'hFFFFFFFFFFFF;
        req_valid[1]    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_req_ready", 64'(req_ready), 64'(0));
            checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            checkOutput("bp_rsp_data", 64'(rsp_data), 64'(32'h40DA4917));
            checkOutput("bp_rsp_id", 64'(rsp_id), 64'(0));
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_drain_grant", 64'(req_ready), 64'(2'b10));
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        checkOutput("bp_next_valid", 64'(rsp_valid), 64'(1));
        checkOutput("bp_next_id", 64'(rsp_id), 64'(1));
        checkOutput("bp_next_data", 64'(rsp_data), 64'(32'hD9CE3DCB));
        @(posedge clk);
        #1;

        rsp_ready = 1'b0;
        applyStimulus(0, 48'h041041041041, waited);
        req_data[95:48] = 48'h79E79E79E79E;
        req_valid[1]    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("wd_req_ready", 64'(req_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        req_valid[1] = 1'b0;
        rsp_ready    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("wd_no_id1_rsp", 64'(rsp_valid && (rsp_id == 2'd1)), 64'(0));
            @(posedge clk);
            #1;
        end

        // Grant to requester 0 leaves ptr at 1, so a post-reset grant to 0 shows ptr was cleared.
        rsp_ready = 1'b0;
        applyStimulus(0, 48'hFFFFFFFFFFFF, waited);
        checkOutput("pre_rst_rsp_valid", 64'(rsp_valid), 64'(1));
        @(posedge clk);
        #3;
        req_data  = {48'h000000000000, 48'hFFFFFFFFFFFF};
        req_valid = 2'b11;
        n_rst     = 1'b0;
        #1;
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'(0));
        checkOutput("rst_rsp_id", 64'(rsp_id), 64'(0));
        checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #2;
        n_rst     = 1'b1;
        rsp_ready = 1'b1;

        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 6) checkOutput("rr_grant", 64'(req_ready), 64'(1 << (k % 2)));
            if (k > 0) begin
                checkOutput("rr_rsp_valid", 64'(rsp_valid), 64'(1));
                checkOutput("rr_rsp_id", 64'(rsp_id), 64'((k - 1) % 2));
            end
            @(posedge clk);
            #1;
            if (k < 6) begin
                rnd = {$urandom(), $urandom()};
                req_data[48*(k % 2) +: 48] = rnd[47:0];
            end
            if (k == 5) req_valid = '0;
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nErrors);
        $finish;
    end

endmodule
